binary_to_bcd_seq: RTL
======================

# binary_to_bcd_seq

- Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock.
- Successor to the fixed 8-bit/3-digit converter in the display path of the sequential multiplier: arbitrary input width, configurable digit count, optional two's-complement input, overflow detection, and explicit valid/ready handshakes on both sides instead of change-detection on the input.
- Sits between arithmetic result registers and the seven-segment digit drivers.

## Interface
- `WIDTH`, default 8: binary input width in bits, ≥ 1.
- `DIGITS`, default 3: number of BCD output digits, ≥ 1.
- `SIGNED`, default 0: 1 treats `bin_in` as two's complement and converts the magnitude; 0 treats it as unsigned.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `bin_in` input, `WIDTH` bits: value to convert; sampled only on the accept edge.
- `in_valid` input, 1 bit: `bin_in` is valid.
- `in_ready` output, 1 bit: block can accept; high only in IDLE.
- `bcd_out` output, 4*`DIGITS` bits: packed BCD result; digit 0 (units) is in [3:0].
- `sign_out` output, 1 bit: result is negative; always 0 when `SIGNED`=0.
- `overflow` output, 1 bit: value ≥ 10^`DIGITS`; `bcd_out` then holds the value mod 10^`DIGITS`.
- `out_valid` output, 1 bit: result is valid; high only in DONE.
- `out_ready` input, 1 bit: consumer takes the result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on `in_valid`&`in_ready` (the accept edge). On that edge:
  - Load the magnitude into the shift register (`WIDTH` binary bits plus 4*`DIGITS` BCD bits, BCD part cleared).
  - Clear the overflow accumulator and the bit counter.
  - Capture the sign.
- Magnitude rules:
  - `SIGNED`=0: magnitude is `bin_in`.
  - `SIGNED`=1 and MSB set: magnitude is the `WIDTH`-bit two's-complement negation, read as unsigned, so the most negative input (e.g. 0x80 → 128) converts correctly.
  - `sign_out` is 1 only when `SIGNED`=1 and the MSB is set.
- SHIFT step, every cycle:
  - Every digit ≥ 5 gets +3, all digits in parallel.
  - The whole register then shifts left by 1.
  - The bit shifted out of the top digit's MSB is ORed into the overflow accumulator.
  - The counter increments.
- SHIFT → DONE on the edge that performs the `WIDTH`th shift. On that edge, load `bcd_out`, `sign_out` and `overflow` from the final register and accumulator.
- DONE: `out_valid`=1, `in_ready`=0. Outputs hold stable until `out_valid`&`out_ready`; on that edge → IDLE.
- `bcd_out`, `sign_out` and `overflow` keep their last value in IDLE and SHIFT. They change only on the SHIFT→DONE edge.
- `bin_in` and `in_valid` are ignored outside IDLE. No input overlap: one conversion in flight.
- Zero input: `bcd_out`=0, `overflow`=0, `sign_out`=0.
- The counter is wide enough for `WIDTH` (clog2(`WIDTH`+1) bits). It resets to 0 on every accept.

## Timing
- Reset values (after `rst` high at an edge): state IDLE, `in_ready`=1, `out_valid`=0, `bcd_out`=0, `sign_out`=0, `overflow`=0, counter 0, shift register 0.
- `rst` has priority over every other event. Reset mid-SHIFT or in DONE aborts the conversion: no `out_valid` pulse, result discarded.
- Latency: if accept happens at edge N, shifts occur at edges N+1 … N+`WIDTH`, and `out_valid` is high from edge N+`WIDTH` onward. That is `WIDTH` cycles.
- Minimum initiation interval is `WIDTH`+2 cycles: accept, `WIDTH` shifts, one IDLE cycle after the DONE handshake.
- `in_ready` and `out_valid` are decoded from state registers only: no combinational path from `in_valid` or `out_ready`.
- `out_ready` high while not in DONE has no effect.

## Test plan
- Default parameters: accept 0xFF → exactly 8 cycles later `out_valid`=1, `bcd_out`=0x255, `overflow`=0, `sign_out`=0. Also accept 0x00 → `bcd_out`=0x000.
- `WIDTH`=16, `DIGITS`=5: accept 65535 → after 16 cycles `bcd_out`=0x65535. Also accept 10000 → 0x10000.
- `SIGNED`=1, `WIDTH`=8:
  - 0x80 → `sign_out`=1, `bcd_out`=0x128.
  - 0xF6 → `sign_out`=1, 0x010.
  - 0x7F → `sign_out`=0, 0x127.
- `WIDTH`=8, `DIGITS`=2:
  - 255 → `overflow`=1, `bcd_out`=0x55.
  - 99 → `overflow`=0, 0x99.
  - 100 → `overflow`=1, 0x00.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `bcd_out` stable, `in_ready`=0, `in_valid` pulses with new `bin_in` ignored. Release → IDLE one cycle later, then the next value is accepted.
- Reset and input-change cases:
  - Assert `rst` at shift 4 of a conversion of 200 → all outputs return to reset values, no `out_valid`. A subsequent conversion of 37 → 0x037 with correct latency.
  - Change `bin_in` mid-SHIFT → result unaffected.

Source files
------------

// File: rtl/binary_to_bcd_seq_if.sv
// rtl/binary_to_bcd_seq_if.sv - handshake bundle for the sequential binary-to-BCD converter
interface binary_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    bin_in;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                sign_out;
  logic                overflow;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  bin_in, in_valid, out_ready,
    output in_ready, bcd_out, sign_out, overflow, out_valid
  );

  modport master (
    output bin_in, in_valid, out_ready,
    input  in_ready, bcd_out, sign_out, overflow, out_valid
  );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// rtl/binary_to_bcd_seq.sv - double-dabble binary-to-BCD converter, one shift per clock
module binary_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst,
  binary_to_bcd_seq_if.slave  bus
);
  localparam int BCDW = 4 * DIGITS;
  localparam int SRW  = WIDTH + BCDW;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SRW-1:0]  r_sr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf_acc;
  logic            r_sign;
  logic [BCDW-1:0] r_bcd;
  logic            r_sign_out;
  logic            r_ovf_out;

  logic            w_accept;
  logic            w_neg;
  logic [WIDTH-1:0] w_mag;
  logic [SRW-1:0]  w_adj;
  logic [SRW-1:0]  w_shifted;
  logic            w_last;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_neg    = (SIGNED != 0) && bus.bin_in[WIDTH-1];
  // Negating in WIDTH bits and reading unsigned makes the most negative input convert to 2^(WIDTH-1).
  assign w_mag    = w_neg ? (~bus.bin_in + WIDTH'(1)) : bus.bin_in;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_adj = r_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sr[WIDTH + 4*d +: 4] >= 4'd5) begin
        w_adj[WIDTH + 4*d +: 4] = r_sr[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted = {w_adj[SRW-2:0], 1'b0};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_ovf_acc  <= 1'b0;
      r_sign     <= 1'b0;
      r_bcd      <= '0;
      r_sign_out <= 1'b0;
      r_ovf_out  <= 1'b0;
    end else if (w_accept) begin
      r_sr      <= {{BCDW{1'b0}}, w_mag};
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_sign    <= w_neg;
    end else if (r_state == S_SHIFT) begin
      r_sr      <= w_shifted;
      r_cnt     <= r_cnt + CW'(1);
      // Any bit leaving the top digit means the value needed more digits than we have.
      r_ovf_acc <= r_ovf_acc | w_adj[SRW-1];
      if (w_last) begin
        r_bcd      <= w_shifted[SRW-1 -: BCDW];
        r_sign_out <= r_sign;
        r_ovf_out  <= r_ovf_acc | w_adj[SRW-1];
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.bcd_out   = r_bcd;
  assign bus.sign_out  = r_sign_out;
  assign bus.overflow  = r_ovf_out;
endmodule
